// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encodings and payload types for the memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned W_ADDR   = 32;
    localparam int unsigned W_DATA   = 32;
    localparam int unsigned W_ARB_ST = 2;

    // Arbiter FSM states
    typedef enum logic [W_ARB_ST-1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_EX_BUSY = 2'd2
    } arb_state_t;

    // Outcome of one arbitration decision
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_EX   = 2'd2
    } grant_t;

    // Command latched towards the memory port for the duration of an access
    typedef struct packed {
        logic              we;
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF, EX and memory-port signals around the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req_i;
    logic [W_ADDR-1:0] if_addr_i;
    logic              if_ack_o;
    logic [W_DATA-1:0] if_rdata_o;

    logic              ex_req_i;
    logic              ex_we_i;
    logic [W_ADDR-1:0] ex_addr_i;
    logic [W_DATA-1:0] ex_wdata_i;
    logic              ex_ack_o;
    logic [W_DATA-1:0] ex_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [W_ADDR-1:0] mem_addr_o;
    logic [W_DATA-1:0] mem_wdata_o;
    logic [W_DATA-1:0] mem_rdata_i;
    logic              mem_ack_i;

    logic              busy_o;

    // Arbiter side
    modport slave (
        input  if_req_i, if_addr_i,
        output if_ack_o, if_rdata_o,
        input  ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
        output ex_ack_o, ex_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i,
        output busy_o
    );

    // Requester / memory-model side
    modport master (
        output if_req_i, if_addr_i,
        input  if_ack_o, if_rdata_o,
        output ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
        input  ex_ack_o, ex_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i,
        input  busy_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port main memory between instruction fetch and load/store.
// One access outstanding at a time; EX has priority unless it won the last grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state;
    logic              last_ex;
    mem_cmd_t          cmd;
    logic              mem_req;
    logic              if_ack;
    logic              ex_ack;
    logic              busy;
    logic [W_DATA-1:0] if_rdata;
    logic [W_DATA-1:0] ex_rdata;
    grant_t            grant;

    // EX wins ties unless it holds the previous grant and IF is waiting
    function automatic grant_t arb_pick(input logic if_req, input logic ex_req,
                                        input logic prev_ex);
        grant_t g;
        g = GNT_NONE;
        if (ex_req && !(prev_ex && if_req)) begin
            g = GNT_EX;
        end else if (if_req) begin
            g = GNT_IF;
        end
        return g;
    endfunction

    // A requester being acked this cycle still shows its old req; mask it out
    always_comb begin
        grant = arb_pick(bus.if_req_i && !if_ack, bus.ex_req_i && !ex_ack, last_ex);
    end

    // Access sequencer: grant, hold the memory command, return data and ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            last_ex  <= 1'b0;
            cmd      <= '0;
            mem_req  <= 1'b0;
            if_ack   <= 1'b0;
            ex_ack   <= 1'b0;
            busy     <= 1'b0;
            if_rdata <= '0;
            ex_rdata <= '0;
        end else begin
            if_ack <= 1'b0;
            ex_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant == GNT_EX) begin
                        state   <= ST_EX_BUSY;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        last_ex <= 1'b1;
                        cmd     <= '{we: bus.ex_we_i, addr: bus.ex_addr_i,
                                     wdata: bus.ex_wdata_i};
                    end else if (grant == GNT_IF) begin
                        state   <= ST_IF_BUSY;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        last_ex <= 1'b0;
                        cmd     <= '{we: 1'b0, addr: bus.if_addr_i,
                                     wdata: cmd.wdata};
                    end
                end
                ST_IF_BUSY: begin
                    if (bus.mem_ack_i) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        mem_req  <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= bus.mem_rdata_i;
                    end
                end
                ST_EX_BUSY: begin
                    if (bus.mem_ack_i) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        ex_ack  <= 1'b1;
                        // Stores leave the load-data register untouched
                        if (!cmd.we) begin
                            ex_rdata <= bus.mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs onto the bus
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = cmd.we;
    assign bus.mem_addr_o  = cmd.addr;
    assign bus.mem_wdata_o = cmd.wdata;
    assign bus.if_ack_o    = if_ack;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.ex_ack_o    = ex_ack;
    assign bus.ex_rdata_o  = ex_rdata;
    assign bus.busy_o      = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple wait-state memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory model: acks once mem_req_o has been high for mem_delay cycles
    int unsigned       mem_delay = 0;
    int unsigned       wait_cnt;
    logic [W_DATA-1:0] rd_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 0;
        end else if (bus.mem_req_o && !bus.mem_ack_i) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    assign bus.mem_ack_i   = bus.mem_req_o && (wait_cnt >= mem_delay);
    assign bus.mem_rdata_i = rd_val;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.ex_req_i = 1'b0; bus.ex_we_i = 1'b0;
        bus.ex_addr_i = '0;  bus.ex_wdata_i = '0;
        rd_val = '0;
        repeat (3) tick();
        vectors++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.if_ack_o, bus.ex_ack_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.if_ack_o, bus.ex_ack_o});
        end
        vectors++;
        if ({bus.if_rdata_o, bus.ex_rdata_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h %h want all zero",
                     bus.if_rdata_o, bus.ex_rdata_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_ex_load();
        rd_val = 32'h0000_CAFE; mem_delay = 0;
        bus.ex_we_i = 1'b0; bus.ex_addr_i = 32'h10; bus.ex_req_i = 1'b1;
        tick();
        vectors++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.mem_addr_o} !== {3'b101, 32'h10}) begin
            miscompares++;
            $display("FAIL ex_load_grant: got req/we/busy=%b addr=%h want 101 addr=00000010",
                     {bus.mem_req_o, bus.mem_we_o, bus.busy_o}, bus.mem_addr_o);
        end
        tick();
        vectors++;
        if ({bus.ex_ack_o, bus.if_ack_o, bus.ex_rdata_o} !== {2'b10, 32'h0000_CAFE}) begin
            miscompares++;
            $display("FAIL ex_load_ack: got ex/if ack=%b rdata=%h want 10 0000cafe",
                     {bus.ex_ack_o, bus.if_ack_o}, bus.ex_rdata_o);
        end
        bus.ex_req_i = 1'b0;
        tick();
        vectors++;
        if ({bus.ex_ack_o, bus.busy_o, bus.mem_req_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL ex_load_done: got ack/busy/req=%b want 000",
                     {bus.ex_ack_o, bus.busy_o, bus.mem_req_o});
        end
    endtask

    task automatic test_ex_store();
        int ack_cnt = 0;
        int ack_at  = 0;
        rd_val = 32'hDEAD_BEEF; mem_delay = 3;
        bus.ex_we_i = 1'b1; bus.ex_addr_i = 32'd8; bus.ex_wdata_i = 32'd5; bus.ex_req_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.mem_req_o) begin
                vectors++;
                if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 32'd8, 32'd5}) begin
                    miscompares++;
                    $display("FAIL ex_store_cmd: got we=%b addr=%h wdata=%h want 1 8 5",
                             bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
                end
            end
            if (bus.ex_ack_o) begin
                ack_cnt++;
                if (ack_at == 0) ack_at = c;
                bus.ex_req_i = 1'b0;
                vectors++;
                if (bus.ex_rdata_o !== 32'h0000_CAFE) begin
                    miscompares++;
                    $display("FAIL ex_store_rdata: got %h want 0000cafe", bus.ex_rdata_o);
                end
            end
        end
        vectors++;
        if (ack_cnt != 1 || ack_at != 5) begin
            miscompares++;
            $display("FAIL ex_store_ack: got %0d acks at cycle %0d want 1 at cycle 5", ack_cnt, ack_at);
        end
        mem_delay = 0;
    endtask

    task automatic test_if_read();
        rd_val = 32'h1234; mem_delay = 0;
        bus.if_addr_i = 32'h40; bus.if_req_i = 1'b1;
        tick();
        vectors++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.if_ack_o, bus.mem_addr_o} !== {4'b1010, 32'h40}) begin
            miscompares++;
            $display("FAIL if_grant: got req/we/busy/ack=%b addr=%h want 1010 addr=00000040",
                     {bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.if_ack_o}, bus.mem_addr_o);
        end
        tick();
        vectors++;
        if ({bus.if_ack_o, bus.ex_ack_o, bus.if_rdata_o} !== {2'b10, 32'h1234}) begin
            miscompares++;
            $display("FAIL if_ack: got if/ex ack=%b rdata=%h want 10 00001234",
                     {bus.if_ack_o, bus.ex_ack_o}, bus.if_rdata_o);
        end
        bus.if_req_i = 1'b0;
        tick();
        vectors++;
        if ({bus.if_ack_o, bus.busy_o} !== 2'b00 || bus.ex_rdata_o !== 32'h0000_CAFE) begin
            miscompares++;
            $display("FAIL if_done: got ack/busy=%b ex_rdata=%h want 00 0000cafe",
                     {bus.if_ack_o, bus.busy_o}, bus.ex_rdata_o);
        end
    endtask

    task automatic test_alternate();
        logic prev = 1'b0;
        logic owner_ex;
        int   n = 0;
        rd_val = 32'h5555; mem_delay = 1;
        bus.if_addr_i = 32'h100; bus.ex_addr_i = 32'h200; bus.ex_we_i = 1'b0;
        bus.if_req_i = 1'b1; bus.ex_req_i = 1'b1;
        for (int c = 0; c < 60 && n < 8; c++) begin
            tick();
            if (bus.mem_req_o && !prev) begin
                owner_ex = (bus.mem_addr_o == 32'h200);
                vectors++;
                if (owner_ex !== ((n % 2) == 0)) begin
                    miscompares++;
                    $display("FAIL alt_order: grant %0d got ex=%b want ex=%b", n, owner_ex, (n % 2) == 0);
                end
                n++;
            end
            prev = bus.mem_req_o;
            vectors++;
            if (bus.if_ack_o && bus.ex_ack_o) begin
                miscompares++;
                $display("FAIL alt_onehot: got both acks high want at most one");
            end
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL alt_timeout: got %0d grants want 8", n);
        end
        bus.if_req_i = 1'b0; bus.ex_req_i = 1'b0;
        repeat (8) tick();
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL alt_drain: got busy=%b want 0", bus.busy_o);
        end
    endtask

    task automatic test_ack_rearb();
        logic seen;
        int   extra;
        mem_delay = 0; rd_val = 32'h77;
        for (int r = 0; r < 2; r++) begin
            seen = 1'b0; extra = 0;
            if (r == 0) begin
                bus.if_addr_i = 32'h300; bus.if_req_i = 1'b1;
            end else begin
                bus.ex_addr_i = 32'h400; bus.ex_we_i = 1'b0; bus.ex_req_i = 1'b1;
            end
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                seen = (r == 0) ? bus.if_ack_o : bus.ex_ack_o;
            end
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL rearb_timeout: requester %0d got no ack want ack", r);
            end
            tick();
            vectors++;
            if ({bus.mem_req_o, bus.busy_o} !== 2'b00) begin
                miscompares++;
                $display("FAIL rearb_dup: requester %0d got req/busy=%b want 00", r,
                         {bus.mem_req_o, bus.busy_o});
            end
            bus.if_req_i = 1'b0; bus.ex_req_i = 1'b0;
            repeat (4) begin
                tick();
                if (bus.if_ack_o || bus.ex_ack_o || bus.mem_req_o) extra++;
            end
            vectors++;
            if (extra != 0) begin
                miscompares++;
                $display("FAIL rearb_extra: requester %0d got %0d active cycles want 0", r, extra);
            end
        end
    endtask

    task automatic test_random();
        logic              prev_req = 1'b0;
        logic [W_ADDR-1:0] p_addr = '0;
        logic              p_we = 1'b0;
        logic [W_DATA-1:0] p_wdata = '0;
        logic              owner_ex = 1'b0;
        logic              cur_we = 1'b0;
        logic              ex_known = 1'b0;
        logic [W_DATA-1:0] exp_ex = '0;
        int if_raised = 0, ex_raised = 0, if_acks = 0, ex_acks = 0, cyc = 0;
        bus.if_req_i = 1'b0; bus.ex_req_i = 1'b0; mem_delay = 0;
        while (cyc < 400 || bus.if_req_i || bus.ex_req_i) begin
            if (cyc >= 480) break;
            tick();
            cyc++;
            vectors++;
            if (bus.if_ack_o && bus.ex_ack_o) begin
                miscompares++;
                $display("FAIL rnd_onehot: cycle %0d got both acks want at most one", cyc);
            end
            if (bus.if_ack_o) begin
                if_acks++;
                vectors++;
                if (owner_ex !== 1'b0 || bus.if_rdata_o !== rd_val) begin
                    miscompares++;
                    $display("FAIL rnd_if_ack: owner_ex=%b rdata=%h want owner_ex=0 rdata=%h",
                             owner_ex, bus.if_rdata_o, rd_val);
                end
                bus.if_req_i = 1'b0;
            end
            if (bus.ex_ack_o) begin
                ex_acks++;
                vectors++;
                if (owner_ex !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rnd_ex_owner: got owner_ex=%b want 1", owner_ex);
                end
                if (!cur_we) begin
                    exp_ex = rd_val; ex_known = 1'b1;
                end
                if (ex_known) begin
                    vectors++;
                    if (bus.ex_rdata_o !== exp_ex) begin
                        miscompares++;
                        $display("FAIL rnd_ex_rdata: got %h want %h", bus.ex_rdata_o, exp_ex);
                    end
                end
                bus.ex_req_i = 1'b0;
            end
            if (bus.mem_req_o && prev_req) begin
                vectors++;
                if ({bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o} !== {p_addr, p_we, p_wdata}) begin
                    miscompares++;
                    $display("FAIL rnd_stable: got %h/%b/%h want %h/%b/%h", bus.mem_addr_o,
                             bus.mem_we_o, bus.mem_wdata_o, p_addr, p_we, p_wdata);
                end
            end
            if (bus.mem_req_o && !prev_req) begin
                owner_ex  = bus.mem_addr_o[W_ADDR-1];
                cur_we    = bus.mem_we_o;
                mem_delay = $urandom_range(0, 7);
                rd_val    = $urandom;
                if (!owner_ex) begin
                    vectors++;
                    if (bus.mem_we_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_if_we: got %b want 0", bus.mem_we_o);
                    end
                end
            end
            p_addr = bus.mem_addr_o; p_we = bus.mem_we_o; p_wdata = bus.mem_wdata_o;
            prev_req = bus.mem_req_o;
            if (cyc < 400) begin
                if (!bus.if_req_i && !bus.if_ack_o && ($urandom_range(0, 1) == 1)) begin
                    bus.if_req_i  = 1'b1;
                    bus.if_addr_i = {1'b0, 31'($urandom)};
                    if_raised++;
                end
                if (!bus.ex_req_i && !bus.ex_ack_o && ($urandom_range(0, 1) == 1)) begin
                    bus.ex_req_i   = 1'b1;
                    bus.ex_we_i    = 1'($urandom_range(0, 1));
                    bus.ex_addr_i  = {1'b1, 31'($urandom)};
                    bus.ex_wdata_i = $urandom;
                    ex_raised++;
                end
            end
        end
        vectors++;
        if (if_acks != if_raised || ex_acks != ex_raised) begin
            miscompares++;
            $display("FAIL rnd_counts: got if/ex acks %0d/%0d want %0d/%0d",
                     if_acks, ex_acks, if_raised, ex_raised);
        end
        bus.if_req_i = 1'b0; bus.ex_req_i = 1'b0;
        tick();
        mem_delay = 0;
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        mem_delay = 100;
        bus.ex_we_i = 1'b0; bus.ex_addr_i = 32'h500; bus.ex_req_i = 1'b1;
        tick();
        vectors++;
        if ({bus.mem_req_o, bus.busy_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_pre: got req/busy=%b want 11", {bus.mem_req_o, bus.busy_o});
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_req_o, bus.busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_drop: got req/busy=%b want 00", {bus.mem_req_o, bus.busy_o});
        end
        bus.ex_req_i = 1'b0;
        tick();
        rst = 1'b1;
        mem_delay = 0;
        repeat (10) begin
            tick();
            if (bus.ex_ack_o || bus.if_ack_o || bus.mem_req_o) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL rstmid_noack: got %0d active cycles after release want 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_ex_load();
        test_ex_store();
        test_if_read();
        test_alternate();
        test_ack_rearb();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
